// File: rtl/mem_lsu_pkg.sv
// mem_lsu_pkg: shared widths, fault causes, FSM states and record types for the MEM-stage load/store unit.
package mem_lsu_pkg;
    localparam logic [2:0] BYTE   = 3'd1;
    localparam logic [2:0] HALF   = 3'd2;
    localparam logic [2:0] WORD   = 3'd3;
    localparam logic [2:0] DOUBLE = 3'd4;
    localparam int LSU_ADDR_WIDTH = 10;
    localparam logic [1:0] FAULT_MISALIGN = 2'd0;
    localparam logic [1:0] FAULT_RANGE    = 2'd1;
    localparam logic [1:0] FAULT_TIMEOUT  = 2'd2;
    typedef enum logic [1:0] {IDLE, BUSY, DONE} lsu_state_t;
    typedef struct packed {
        logic [31:0] Data;
        logic [4:0]  Rd;
        logic        RegWrite;
    } mem_record_t;
    typedef struct packed {
        logic                      We;
        logic [LSU_ADDR_WIDTH-1:0] Addr;
        logic [3:0]                Be;
        logic [31:0]               WData;
    } lsu_req_t;
endpackage

// File: rtl/mem_lsu_if.sv
// mem_lsu_if: pipeline-side and RAM-side signals of the load/store unit.
//   master: the LSU view (consumes i_*, drives o_*).
//   slave:  the pipeline/RAM view (drives i_*, consumes o_*).
interface mem_lsu_if #(parameter int ADDR_WIDTH = 10);
    logic                  i_Valid;
    logic                  i_MemRead;
    logic                  i_MemWrite;
    logic [2:0]            i_LSWidth;
    logic                  i_SignExtend;
    logic [31:0]           i_Addr;
    logic [31:0]           i_StoreData;
    logic                  o_Stall;
    logic [31:0]           o_LoadData;
    logic                  o_Done;
    logic                  o_Fault;
    logic [1:0]            o_FaultCause;
    logic                  o_MemReq;
    logic                  o_MemWe;
    logic [ADDR_WIDTH-1:0] o_MemAddr;
    logic [31:0]           o_MemWData;
    logic [3:0]            o_MemBe;
    logic                  i_MemAck;
    logic [31:0]           i_MemRData;
    modport master (
        input  i_Valid, i_MemRead, i_MemWrite, i_LSWidth, i_SignExtend, i_Addr, i_StoreData,
        input  i_MemAck, i_MemRData,
        output o_Stall, o_LoadData, o_Done, o_Fault, o_FaultCause,
        output o_MemReq, o_MemWe, o_MemAddr, o_MemWData, o_MemBe
    );
    modport slave (
        output i_Valid, i_MemRead, i_MemWrite, i_LSWidth, i_SignExtend, i_Addr, i_StoreData,
        output i_MemAck, i_MemRData,
        input  o_Stall, o_LoadData, o_Done, o_Fault, o_FaultCause,
        input  o_MemReq, o_MemWe, o_MemAddr, o_MemWData, o_MemBe
    );
endinterface

// File: rtl/mem_lsu_lane_format.sv
// lsu_lane_format: combinational byte-lane steering for the load/store unit.
//   st_*: store width/offset/data in -> byte enables and replicated write data out.
//   ld_*: latched width/offset/sign mode plus RAM word in -> extended load value out.
module lsu_lane_format
    import mem_lsu_pkg::*;
(
    input  logic [2:0]  st_width,
    input  logic [1:0]  st_off,
    input  logic [31:0] st_data,
    output logic [3:0]  st_be,
    output logic [31:0] st_wdata,
    input  logic [2:0]  ld_width,
    input  logic [1:0]  ld_off,
    input  logic        ld_sext,
    input  logic [31:0] ld_rdata,
    output logic [31:0] ld_data
);
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    always_comb begin
        st_be    = st_width == BYTE ? 4'b0001 << st_off :
                   st_width == HALF ? 4'b0011 << st_off :
                   st_width == WORD ? 4'b1111 : 4'b0000;
        st_wdata = st_width == BYTE ? {4{st_data[7:0]}} :
                   st_width == HALF ? {2{st_data[15:0]}} : st_data;
        // Halfwords are 2-byte aligned, so only the upper offset bit picks the lane.
        ld_byte  = ld_rdata[{ld_off, 3'b000} +: 8];
        ld_half  = ld_rdata[{ld_off[1], 4'b0000} +: 16];
        ld_data  = ld_width == BYTE ? {{24{ld_sext & ld_byte[7]}}, ld_byte} :
                   ld_width == HALF ? {{16{ld_sext & ld_half[15]}}, ld_half} : ld_rdata;
    end
endmodule

// File: rtl/mem_lsu.sv
// mem_lsu: MEM-stage load/store unit between the EX/MEM register and the word-addressed data RAM.
//   i_CLK/i_RST: clock and synchronous active-high reset.
//   bus (master): pipeline request in, stall/done/fault/load result out, registered RAM request out, ack/rdata in.
module mem_lsu
    import mem_lsu_pkg::*;
#(
    parameter int ADDR_WIDTH  = LSU_ADDR_WIDTH,
    parameter int ACK_TIMEOUT = 16
)(
    input  logic      i_CLK,
    input  logic      i_RST,
    mem_lsu_if.master bus
);
    localparam int CW = $clog2(ACK_TIMEOUT + 1);
    lsu_state_t  state_q, state_d;
    lsu_req_t    req_q, req_d;
    logic        req_valid_q, req_valid_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]  off_q, off_d;
    logic [2:0]  width_q, width_d;
    logic        sext_q, sext_d;
    logic [31:0] load_data_q, load_data_d;
    logic        fault_q, fault_d;
    logic [1:0]  cause_q, cause_d;
    logic        stall, start, illegal, out_of_range, misaligned;
    logic [3:0]  st_be;
    logic [31:0] st_wdata, ld_data;

    lsu_lane_format u_fmt (
        .st_width (bus.i_LSWidth),
        .st_off   (bus.i_Addr[1:0]),
        .st_data  (bus.i_StoreData),
        .st_be    (st_be),
        .st_wdata (st_wdata),
        .ld_width (width_q),
        .ld_off   (off_q),
        .ld_sext  (sext_q),
        .ld_rdata (bus.i_MemRData),
        .ld_data  (ld_data)
    );

    assign start        = bus.i_Valid & (bus.i_MemRead | bus.i_MemWrite);
    assign illegal      = (bus.i_MemRead & bus.i_MemWrite) ||
                          !(bus.i_LSWidth inside {BYTE, HALF, WORD});
    assign out_of_range = |bus.i_Addr[31:ADDR_WIDTH+2];
    assign misaligned   = (bus.i_LSWidth == HALF && bus.i_Addr[0]) ||
                          (bus.i_LSWidth == WORD && bus.i_Addr[1:0] != 2'b00);

    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        req_valid_d = req_valid_q;
        cnt_d       = cnt_q;
        off_d       = off_q;
        width_d     = width_q;
        sext_d      = sext_q;
        load_data_d = load_data_q;
        fault_d     = 1'b0;
        cause_d     = cause_q;
        stall       = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                if (illegal || out_of_range || misaligned) begin
                    fault_d = 1'b1;
                    cause_d = (illegal || out_of_range) ? FAULT_RANGE : FAULT_MISALIGN;
                end else begin
                    req_d.We    = bus.i_MemWrite;
                    req_d.Addr  = bus.i_Addr[ADDR_WIDTH+1:2];
                    req_d.Be    = st_be;
                    req_d.WData = st_wdata;
                    req_valid_d = 1'b1;
                    off_d       = bus.i_Addr[1:0];
                    width_d     = bus.i_LSWidth;
                    sext_d      = bus.i_SignExtend;
                    cnt_d       = '0;
                    stall       = 1'b1;
                    state_d     = BUSY;
                end
            end
            BUSY: begin
                stall = 1'b1;
                if (bus.i_MemAck) begin
                    load_data_d = req_q.We ? load_data_q : ld_data;
                    req_d       = '0;
                    req_valid_d = 1'b0;
                    state_d     = DONE;
                end else if (cnt_q == CW'(ACK_TIMEOUT - 1)) begin
                    req_d       = '0;
                    req_valid_d = 1'b0;
                    fault_d     = 1'b1;
                    cause_d     = FAULT_TIMEOUT;
                    state_d     = IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            // The pipeline advances on this edge; the instruction still presented is the one just finished.
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            state_q     <= IDLE;
            req_q       <= '0;
            req_valid_q <= 1'b0;
            cnt_q       <= '0;
            off_q       <= '0;
            width_q     <= '0;
            sext_q      <= 1'b0;
            load_data_q <= '0;
            fault_q     <= 1'b0;
            cause_q     <= '0;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            req_valid_q <= req_valid_d;
            cnt_q       <= cnt_d;
            off_q       <= off_d;
            width_q     <= width_d;
            sext_q      <= sext_d;
            load_data_q <= load_data_d;
            fault_q     <= fault_d;
            cause_q     <= cause_d;
        end
    end

    assign bus.o_Stall      = stall;
    assign bus.o_LoadData   = load_data_q;
    assign bus.o_Done       = state_q == DONE;
    assign bus.o_Fault      = fault_q;
    assign bus.o_FaultCause = cause_q;
    assign bus.o_MemReq     = req_valid_q;
    assign bus.o_MemWe      = req_q.We;
    assign bus.o_MemAddr    = req_q.Addr;
    assign bus.o_MemBe      = req_q.Be;
    assign bus.o_MemWData   = req_q.WData;
endmodule

// File: tb/tb_mem_lsu.sv
// tb_mem_lsu: directed bench for mem_lsu with a transaction-level expectation model and per-cycle compare.
module tb_mem_lsu;
    import mem_lsu_pkg::*;
    localparam int AW = 10;
    localparam int TO = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_lsu_if #(.ADDR_WIDTH(AW)) bus ();
    mem_lsu #(.ADDR_WIDTH(AW), .ACK_TIMEOUT(TO)) dut (.i_CLK(clk), .i_RST(rst), .bus(bus));

    int checks = 0;
    int errors = 0;
    bit chk_en = 0;
    int stall_cnt, req_cnt;
    logic [3:0]    seen_be;
    logic [31:0]   seen_wdata;
    logic          seen_we;
    logic [AW-1:0] seen_addr;

    logic          e_stall, e_done, e_fault, e_req, e_we;
    logic [1:0]    e_cause;
    logic [AW-1:0] e_addr;
    logic [3:0]    e_be;
    logic [31:0]   e_wdata, e_load;
    logic [31:0]   m_load  = '0;
    logic [1:0]    m_cause = '0;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic int nbytes(input logic [2:0] w);
        return w == BYTE ? 1 : w == HALF ? 2 : w == WORD ? 4 : 0;
    endfunction

    // -1 when the access is legal, otherwise the fault cause it must raise.
    function automatic int m_fault(input logic rd, input logic wr, input logic [2:0] w, input logic [31:0] a);
        int n = nbytes(w);
        if ((rd && wr) || n == 0 || a >= (32'd1 << (AW + 2))) return 1;
        if (a % n != 0) return 0;
        return -1;
    endfunction

    function automatic logic [3:0] m_be(input logic [2:0] w, input logic [31:0] a);
        int n = nbytes(w);
        return 4'(((1 << n) - 1) << (a % 4));
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] w, input logic [31:0] d);
        logic [31:0] r;
        int n = nbytes(w);
        for (int i = 0; i < 4; i++) r[8*i +: 8] = d[8*(i % n) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] m_load_fmt(input logic [2:0] w, input logic sext, input logic [31:0] a,
                                               input logic [31:0] rdata);
        logic [31:0] v, mask;
        int n = nbytes(w);
        v = rdata >> (8 * (a % 4));
        if (n < 4) begin
            mask = (32'd1 << (8 * n)) - 1;
            v = v & mask;
            if (sext && v[8*n-1]) v = v | ~mask;
        end
        return v;
    endfunction

    always @(negedge clk) if (chk_en) begin
        cmp("stall", 32'(bus.o_Stall), 32'(e_stall));
        cmp("done", 32'(bus.o_Done), 32'(e_done));
        cmp("fault", 32'(bus.o_Fault), 32'(e_fault));
        cmp("cause", 32'(bus.o_FaultCause), 32'(e_cause));
        cmp("load_data", bus.o_LoadData, e_load);
        cmp("mem_req", 32'(bus.o_MemReq), 32'(e_req));
        cmp("mem_we", 32'(bus.o_MemWe), 32'(e_we));
        cmp("mem_addr", 32'(bus.o_MemAddr), 32'(e_addr));
        cmp("mem_be", 32'(bus.o_MemBe), 32'(e_be));
        cmp("mem_wdata", bus.o_MemWData, e_wdata);
        if (bus.o_Stall) stall_cnt++;
        if (bus.o_MemReq) begin
            req_cnt++;
            seen_be    = bus.o_MemBe;
            seen_wdata = bus.o_MemWData;
            seen_we    = bus.o_MemWe;
            seen_addr  = bus.o_MemAddr;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        stall_cnt = 0;
        req_cnt   = 0;
        seen_be   = '0;
        seen_wdata = '0;
        seen_we   = 1'b0;
        seen_addr = '0;
    endtask

    task automatic idle_in();
        bus.i_Valid      = 1'b0;
        bus.i_MemRead    = 1'b0;
        bus.i_MemWrite   = 1'b0;
        bus.i_LSWidth    = 3'd0;
        bus.i_SignExtend = 1'b0;
        bus.i_Addr       = '0;
        bus.i_StoreData  = '0;
        bus.i_MemAck     = 1'b0;
        bus.i_MemRData   = 32'h5A5A5A5A;
    endtask

    task automatic quiet_exp();
        e_stall = 1'b0;
        e_done  = 1'b0;
        e_fault = 1'b0;
        e_req   = 1'b0;
        e_we    = 1'b0;
        e_addr  = '0;
        e_be    = '0;
        e_wdata = '0;
        e_load  = m_load;
        e_cause = m_cause;
    endtask

    task automatic busy_exp(input logic wr, input logic [2:0] w, input logic [31:0] a, input logic [31:0] d);
        quiet_exp();
        e_stall = 1'b1;
        e_req   = 1'b1;
        e_we    = wr;
        e_addr  = AW'(a >> 2);
        e_be    = m_be(w, a);
        e_wdata = m_wdata(w, d);
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [2:0] w, input logic sext,
                         input logic [31:0] a, input logic [31:0] d);
        bus.i_Valid      = 1'b1;
        bus.i_MemRead    = rd;
        bus.i_MemWrite   = wr;
        bus.i_LSWidth    = w;
        bus.i_SignExtend = sext;
        bus.i_Addr       = a;
        bus.i_StoreData  = d;
    endtask

    // delay = index of the BUSY cycle carrying the ack; negative means the RAM never answers.
    task automatic acc(input logic rd, input logic wr, input logic [2:0] w, input logic sext,
                       input logic [31:0] a, input logic [31:0] d, input int delay, input logic [31:0] rdata);
        int f;
        int n_busy;
        f = m_fault(rd, wr, w, a);
        drive(rd, wr, w, sext, a, d);
        quiet_exp();
        e_stall = (f < 0);
        step();
        if (f >= 0) begin
            idle_in();
            m_cause = 2'(f);
            quiet_exp();
            e_fault = 1'b1;
            step();
        end else begin
            n_busy = (delay < 0) ? TO : delay + 1;
            for (int k = 0; k < n_busy; k++) begin
                busy_exp(wr, w, a, d);
                bus.i_MemAck   = (k == delay);
                bus.i_MemRData = (k == delay) ? rdata : 32'h5A5A5A5A;
                step();
            end
            bus.i_MemAck   = 1'b0;
            bus.i_MemRData = 32'h5A5A5A5A;
            if (delay >= 0) begin
                if (rd) m_load = m_load_fmt(w, sext, a, rdata);
                quiet_exp();
                e_done = 1'b1;
                step();
            end else begin
                idle_in();
                m_cause = FAULT_TIMEOUT;
                quiet_exp();
                e_fault = 1'b1;
                step();
            end
        end
        idle_in();
        quiet_exp();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        idle_in();
        quiet_exp();
        clr();
        rst = 1'b1;
        step();
        chk_en = 1;
        step();
        rst = 1'b0;
        cmp("rst_load", bus.o_LoadData, 32'h0);
        cmp("rst_be", 32'(bus.o_MemBe), 32'h0);
        cmp("rst_cause", 32'(bus.o_FaultCause), 32'h0);

        clr();
        acc(1, 0, WORD, 0, 32'h0000_0010, 32'h0, 1, 32'hDEADBEEF);
        cmp("lw_load", bus.o_LoadData, 32'hDEADBEEF);
        cmp("lw_stall_cycles", stall_cnt, 3);
        cmp("lw_addr", 32'(seen_addr), 32'h4);
        cmp("lw_be", 32'(seen_be), 32'hF);

        acc(1, 0, BYTE, 1, 32'h13, 32'h0, 0, 32'h80112233);
        cmp("lb_load", bus.o_LoadData, 32'hFFFFFF80);
        clr();
        acc(1, 0, BYTE, 0, 32'h13, 32'h0, 0, 32'h80112233);
        cmp("lbu_load", bus.o_LoadData, 32'h00000080);
        cmp("min_stall_cycles", stall_cnt, 2);

        clr();
        acc(0, 1, HALF, 0, 32'h22, 32'h0000ABCD, 2, 32'hFFFFFFFF);
        cmp("sh_be", 32'(seen_be), 32'hC);
        cmp("sh_wdata", seen_wdata, 32'hABCDABCD);
        cmp("sh_we", 32'(seen_we), 32'h1);
        cmp("sh_load_kept", bus.o_LoadData, 32'h00000080);

        acc(1, 0, HALF, 1, 32'h2, 32'h0, 0, 32'h80017FFF);
        cmp("lh_hi_load", bus.o_LoadData, 32'hFFFF8001);
        acc(1, 0, HALF, 1, 32'h0, 32'h0, 0, 32'h80017FFF);
        cmp("lh_lo_load", bus.o_LoadData, 32'h00007FFF);
        clr();
        acc(0, 1, BYTE, 0, 32'h1, 32'h123456AB, 0, 32'h0);
        cmp("sb_be", 32'(seen_be), 32'h2);
        cmp("sb_wdata", seen_wdata, 32'hABABABAB);
        clr();
        acc(0, 1, WORD, 0, 32'hFFC, 32'hCAFEF00D, 0, 32'h0);
        cmp("sw_top_addr", 32'(seen_addr), 32'h3FF);
        cmp("sw_top_wdata", seen_wdata, 32'hCAFEF00D);

        clr();
        acc(1, 0, WORD, 0, 32'h6, 32'h0, 0, 32'h0);
        cmp("misalign_cause", 32'(bus.o_FaultCause), 32'h0);
        acc(1, 0, DOUBLE, 0, 32'h0, 32'h0, 0, 32'h0);
        cmp("double_cause", 32'(bus.o_FaultCause), 32'h1);
        acc(0, 1, HALF, 0, 32'h5, 32'h0, 0, 32'h0);
        cmp("sh_misalign_cause", 32'(bus.o_FaultCause), 32'h0);
        acc(1, 0, WORD, 0, 32'h1000, 32'h0, 0, 32'h0);
        cmp("range_cause", 32'(bus.o_FaultCause), 32'h1);
        acc(1, 1, WORD, 0, 32'h0, 32'h0, 0, 32'h0);
        acc(1, 0, HALF, 0, 32'h1001, 32'h0, 0, 32'h0);
        cmp("range_over_misalign", 32'(bus.o_FaultCause), 32'h1);
        cmp("fault_no_req", req_cnt, 0);
        cmp("fault_no_stall", stall_cnt, 0);
        cmp("fault_load_kept", bus.o_LoadData, 32'h00007FFF);

        clr();
        acc(1, 0, WORD, 0, 32'h100, 32'h0, -1, 32'h0);
        cmp("timeout_req_cycles", req_cnt, TO);
        cmp("timeout_cause", 32'(bus.o_FaultCause), 32'h2);
        bus.i_MemAck   = 1'b1;
        bus.i_MemRData = 32'h12345678;
        step();
        idle_in();
        step();
        cmp("late_ack_ignored", bus.o_LoadData, 32'h00007FFF);

        drive(1, 0, WORD, 0, 32'h40, 32'h0);
        quiet_exp();
        e_stall = 1'b1;
        step();
        for (int k = 0; k < 3; k++) begin
            busy_exp(0, WORD, 32'h40, 32'h0);
            step();
        end
        rst = 1'b1;
        busy_exp(0, WORD, 32'h40, 32'h0);
        step();
        rst = 1'b0;
        idle_in();
        bus.i_MemAck = 1'b1;
        m_load  = '0;
        m_cause = '0;
        quiet_exp();
        step();
        idle_in();
        cmp("post_rst_load", bus.o_LoadData, 32'h0);
        acc(1, 0, WORD, 0, 32'h44, 32'h0, 0, 32'h01020304);
        cmp("post_rst_lw", bus.o_LoadData, 32'h01020304);

        step();
        chk_en = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_lsu.md
Name: mem_lsu

Overview:
- Load/store unit for the MEM stage. Sits between the EX/MEM pipeline register (ALU result F, store data DS2, LSWidth, SignExtend, MemWrite) and the word-addressed data RAM.
- Produces the formatted load result that fills mem_record_t.Data for the MEM/WB register.
- Generates byte enables and lane-shifted store data, stalls the pipeline across multi-cycle RAM handshakes, and flags misaligned, out-of-range, illegal and timed-out accesses.

Parameters:
- ADDR_WIDTH, 10, RAM word-address width (1K words, 4 KiB).
- ACK_TIMEOUT, 16, BUSY cycles without i_MemAck before a timeout fault (minimum 1).

Ports:
- i_CLK  in  1  clock; all state updates on rising edge.
- i_RST  in  1  synchronous, active-high reset.
- i_Valid  in  1  MEM stage holds a valid instruction.
- i_MemRead  in  1  instruction is a load.
- i_MemWrite  in  1  instruction is a store.
- i_LSWidth  in  3  BYTE=1, HALF=2, WORD=3, DOUBLE=4; any other value is illegal.
- i_SignExtend  in  1  1 = sign-extend loads, 0 = zero-extend.
- i_Addr  in  32  byte address (ALU F).
- i_StoreData  in  32  store source (DS2), right-aligned.
- o_Stall  out  1  freeze IF..MEM stages.
- o_LoadData  out  32  formatted load result, registered.
- o_Done  out  1  one-cycle pulse when an access completes.
- o_Fault  out  1  one-cycle fault pulse.
- o_FaultCause  out  2  0 = misaligned, 1 = range/illegal, 2 = timeout.
- o_MemReq  out  1  RAM request, registered.
- o_MemWe  out  1  RAM write enable.
- o_MemAddr  out  ADDR_WIDTH  word address, i_Addr[ADDR_WIDTH+1:2].
- o_MemWData  out  32  lane-shifted store data.
- o_MemBe  out  4  byte enables.
- i_MemAck  in  1  RAM completes the request; read data is valid in the same cycle.
- i_MemRData  in  32  RAM read word.

Behaviour:
- Reset: state IDLE, timeout counter 0. All outputs are 0, including o_LoadData, o_MemBe and o_FaultCause.
- Reset in BUSY drops o_MemReq on the next edge. Any later i_MemAck arriving in IDLE is ignored.
- start = i_Valid & (i_MemRead | i_MemWrite).
- Checks, evaluated combinationally in IDLE on start:
  - illegal width: i_MemRead & i_MemWrite, or i_LSWidth not in {1,2,3} (DOUBLE is unsupported).
  - range: i_Addr[31:ADDR_WIDTH+2] != 0.
  - misaligned: HALF with i_Addr[0]=1, or WORD with i_Addr[1:0] != 0.
  - Priority: illegal/range (cause 1) over misaligned (cause 0).
- Fault path: on the next edge, o_Fault=1 for one cycle with the cause latched. No request is issued, o_Stall stays 0, and o_LoadData is unchanged.
- FSM: IDLE -> BUSY -> DONE -> IDLE.
  - IDLE, legal start: latch o_MemAddr, o_MemWe=i_MemWrite, o_MemBe, o_MemWData. Set o_MemReq=1 and go to BUSY. o_Stall=1 combinationally in this cycle.
  - BUSY: o_Stall=1 and o_MemReq is held with all request fields stable.
    - i_MemAck: capture the formatted load (loads only), drop o_MemReq, go to DONE.
    - No ack: counter increments. At ACK_TIMEOUT it drops o_MemReq, pulses o_Fault with cause 2, and returns to IDLE.
  - DONE: o_Done=1, o_Stall=0, so the pipeline advances at this edge. start is ignored here because it is the same instruction. Next state is IDLE.
- Minimum latency with ack in the first BUSY cycle: start cycle, 1 BUSY, 1 DONE = 3 cycles, with 2 stall cycles.
- Stores:
  - BYTE: be = 4'b0001 << a[1:0], wdata = {4{d[7:0]}}.
  - HALF: be = 4'b0011 << a[1:0], wdata = {2{d[15:0]}}.
  - WORD: be = 4'b1111, wdata = d.
- Loads: select the lane using the latched a[1:0], then extend to 32 bits per SignExtend. WORD loads ignore SignExtend.
- o_LoadData holds its value until the next completed load. Stores do not modify it.

Decomposition:
- Package types gains:
  - lsu_state_t enum (IDLE, BUSY, DONE).
  - localparams FAULT_MISALIGN=0, FAULT_RANGE=1, FAULT_TIMEOUT=2.
  - lsu_req_t struct (We, Addr, Be, WData).
- The existing BYTE/HALF/WORD/DOUBLE constants and mem_record_t are reused.
- One sub-module: lsu_lane_format, a combinational block handling load extraction/extension and store lane/byte-enable generation.

Test Plan:
- LW at 0x0000_0010, RAM acks after 2 BUSY cycles with 0xDEADBEEF -> o_MemAddr=4, o_MemBe=1111, o_Stall high 3 cycles, o_Done then o_LoadData=0xDEADBEEF.
- LB signed at 0x13 with rdata 0x80112233 -> 0xFFFFFF80. Same access with LBU -> 0x00000080.
- SH data 0x0000ABCD at 0x22 -> o_MemBe=1100, o_MemWData=0xABCDABCD, o_MemWe=1, o_LoadData unchanged.
- LW at 0x0000_0006 -> o_Fault with cause 0, o_MemReq never asserted, o_Stall 0. DOUBLE width, or i_Addr=0x0000_1000 -> cause 1.
- Load with no ack -> o_MemReq high exactly 16 cycles, then o_Fault with cause 2, state IDLE. A later ack is ignored.
- Assert i_RST in BUSY -> o_MemReq=0 and all outputs 0 next cycle. A following legal LW then completes normally.
